// File: rtl/fetch_buffer.sv
// Fetch buffer: queues translated fetches, issues in-order icache requests,
// matches in-order responses back to entries and presents completed entries to decode.
module fetch_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_paddr,
  input  logic [31:0] in_vaddr,
  input  logic        in_uncached,
  input  logic        in_excp,
  input  logic [3:0]  in_excp_num,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [31:0] ic_req_addr,
  output logic        ic_req_uncached,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_excp,
  output logic [3:0]  out_excp_num
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = $clog2(2 * DEPTH) + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Entry payload (not reset)
  logic [31:0] pc_q       [DEPTH];
  logic [31:0] paddr_q    [DEPTH];
  logic [31:0] inst_q     [DEPTH];
  logic [3:0]  excp_num_q [DEPTH];
  logic        unc_q      [DEPTH];
  ptr_t        tag_q      [DEPTH];

  // Entry control bits and pointers
  logic [DEPTH-1:0] excp_q, excp_d, issued_q, issued_d, done_q, done_d;
  ptr_t  head_q, head_d, tail_q, tail_d, issue_q, issue_d, tq_head_q, tq_head_d;
  ptr_t  tq_tail_q, tq_tail_d;
  // iss_cnt counts entries between head and the issue pointer
  cnt_t  count_q, count_d, iss_cnt_q, iss_cnt_d, tq_cnt_q, tq_cnt_d;
  logic [DW-1:0] drop_q, drop_d;

  logic in_fire, iss_pending, req_fire, excp_skip, iss_adv, pop;
  logic resp_live, resp_drop, resp_any;

  // Handshake decode from registered state
  always_comb begin
    in_ready        = (count_q != Full);
    in_fire         = in_valid & in_ready & ~flush;
    iss_pending     = (iss_cnt_q != count_q);
    ic_req_valid    = iss_pending & ~excp_q[issue_q] & ~issued_q[issue_q] & ~flush;
    ic_req_addr     = paddr_q[issue_q];
    ic_req_uncached = unc_q[issue_q];
    req_fire        = ic_req_valid & ic_req_ready;
    // exception entries need no request, the issue pointer just steps past them
    excp_skip       = iss_pending & excp_q[issue_q] & ~flush;
    iss_adv         = req_fire | excp_skip;
    out_valid       = (count_q != '0) & done_q[head_q] & ~flush;
    out_pc          = pc_q[head_q];
    out_inst        = inst_q[head_q];
    out_excp        = excp_q[head_q];
    out_excp_num    = excp_num_q[head_q];
    pop             = out_valid & out_ready;
    resp_drop       = ic_resp_valid & (drop_q != '0);
    resp_live       = ic_resp_valid & (drop_q == '0) & (tq_cnt_q != '0);
    resp_any        = resp_drop | resp_live;
  end

  // Next-state for queue control, tag queue and drop counter
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    issue_d   = issue_q;
    count_d   = count_q;
    iss_cnt_d = iss_cnt_q;
    tq_head_d = tq_head_q;
    tq_tail_d = tq_tail_q;
    tq_cnt_d  = tq_cnt_q;
    drop_d    = drop_q;
    excp_d    = excp_q;
    issued_d  = issued_q;
    done_d    = done_q;
    if (flush) begin
      head_d    = '0;
      tail_d    = '0;
      issue_d   = '0;
      count_d   = '0;
      iss_cnt_d = '0;
      tq_head_d = '0;
      tq_tail_d = '0;
      tq_cnt_d  = '0;
      excp_d    = '0;
      issued_d  = '0;
      done_d    = '0;
      // every request still in flight becomes a response to throw away
      drop_d    = drop_q + DW'(tq_cnt_q) + DW'(req_fire) - DW'(resp_any);
    end else begin
      if (in_fire) begin
        excp_d[tail_q]   = in_excp;
        issued_d[tail_q] = in_excp;
        done_d[tail_q]   = in_excp;
        tail_d           = tail_q + ptr_t'(1);
      end
      if (req_fire) begin
        issued_d[issue_q] = 1'b1;
        tq_tail_d         = tq_tail_q + ptr_t'(1);
      end
      if (iss_adv) begin
        issue_d = issue_q + ptr_t'(1);
      end
      if (resp_live) begin
        done_d[tag_q[tq_head_q]] = 1'b1;
        tq_head_d                = tq_head_q + ptr_t'(1);
      end
      if (resp_drop) begin
        drop_d = drop_q - DW'(1);
      end
      if (pop) begin
        done_d[head_q]   = 1'b0;
        issued_d[head_q] = 1'b0;
        head_d           = head_q + ptr_t'(1);
      end
      count_d   = count_q + cnt_t'(in_fire) - cnt_t'(pop);
      iss_cnt_d = iss_cnt_q + cnt_t'(iss_adv) - cnt_t'(pop);
      tq_cnt_d  = tq_cnt_q + cnt_t'(req_fire) - cnt_t'(resp_live);
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      issue_q   <= '0;
      count_q   <= '0;
      iss_cnt_q <= '0;
      tq_head_q <= '0;
      tq_tail_q <= '0;
      tq_cnt_q  <= '0;
      drop_q    <= '0;
      excp_q    <= '0;
      issued_q  <= '0;
      done_q    <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      issue_q   <= issue_d;
      count_q   <= count_d;
      iss_cnt_q <= iss_cnt_d;
      tq_head_q <= tq_head_d;
      tq_tail_q <= tq_tail_d;
      tq_cnt_q  <= tq_cnt_d;
      drop_q    <= drop_d;
      excp_q    <= excp_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
    end
  end

  // Payload and tag storage, written only on qualified handshakes
  always_ff @(posedge clk) begin
    if (in_fire) begin
      pc_q[tail_q]       <= in_vaddr;
      paddr_q[tail_q]    <= in_paddr;
      unc_q[tail_q]      <= in_uncached;
      excp_num_q[tail_q] <= in_excp_num;
      if (in_excp) begin
        inst_q[tail_q] <= '0;
      end
    end
    if (req_fire) begin
      tag_q[tq_tail_q] <= issue_q;
    end
    if (resp_live && !flush) begin
      inst_q[tag_q[tq_head_q]] <= ic_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_paddr;
  logic [31:0] in_vaddr;
  logic        in_uncached;
  logic        in_excp;
  logic [3:0]  in_excp_num;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_req_uncached;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_excp;
  logic [3:0]  out_excp_num;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_paddr       (in_paddr),
    .in_vaddr       (in_vaddr),
    .in_uncached    (in_uncached),
    .in_excp        (in_excp),
    .in_excp_num    (in_excp_num),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_req_uncached(ic_req_uncached),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_excp       (out_excp),
    .out_excp_num   (out_excp_num)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_vaddr      = '0;
    in_paddr      = '0;
    in_uncached   = 1'b0;
    in_excp       = 1'b0;
    in_excp_num   = '0;
    ic_resp_valid = 1'b0;
    ic_resp_data  = '0;
  endtask

  task automatic fetch(input logic [31:0] va, input logic [31:0] pa, input logic ex,
                       input logic [3:0] num);
    in_valid    = 1'b1;
    in_vaddr    = va;
    in_paddr    = pa;
    in_excp     = ex;
    in_excp_num = num;
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    ic_resp_valid = v;
    ic_resp_data  = d;
  endtask

  // Directed per-cycle vectors: inputs then expected outputs
  typedef struct {
    logic        iv;
    logic [31:0] va;
    logic [31:0] pa;
    logic        ex;
    logic [3:0]  num;
    logic        rv;
    logic [31:0] rd;
    logic        e_rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_out;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_ex;
    logic [3:0]  e_num;
  } vec_t;

  vec_t tbl [18];

  // Reference model: ordered list of live entries plus in-flight request ids
  typedef struct {
    logic [31:0] pc;
    logic [31:0] paddr;
    logic        unc;
    logic        excp;
    logic [3:0]  num;
    logic [31:0] inst;
    bit          done;
    bit          passed;
    int          id;
  } ent_t;

  ent_t mq[$];
  int   outq[$];
  int   stale;
  int   next_id;

  task automatic model_cycle(input int c);
    int   cand;
    bit   e_rdy, e_req, e_out, skip, req_fire, in_fire;
    int   id;
    ent_t t;
    e_rdy = (mq.size() < DEPTH);
    cand  = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (cand < 0 && !mq[i].passed) cand = i;
    end
    e_req = 1'b0;
    skip  = 1'b0;
    if (cand >= 0 && !flush) begin
      if (mq[cand].excp) skip = 1'b1;
      else e_req = 1'b1;
    end
    e_out = 1'b0;
    if (mq.size() > 0 && !flush) e_out = mq[0].done;

    chk($sformatf("rnd%0d in_ready", c), in_ready, e_rdy);
    chk($sformatf("rnd%0d ic_req_valid", c), ic_req_valid, e_req);
    chk($sformatf("rnd%0d out_valid", c), out_valid, e_out);
    if (e_req) begin
      chk($sformatf("rnd%0d ic_req_addr", c), ic_req_addr, mq[cand].paddr);
      chk($sformatf("rnd%0d ic_req_uncached", c), ic_req_uncached, mq[cand].unc);
    end
    if (e_out) begin
      chk($sformatf("rnd%0d out_pc", c), out_pc, mq[0].pc);
      chk($sformatf("rnd%0d out_inst", c), out_inst, mq[0].inst);
      chk($sformatf("rnd%0d out_excp", c), out_excp, mq[0].excp);
      chk($sformatf("rnd%0d out_excp_num", c), out_excp_num, mq[0].num);
    end

    req_fire = e_req && ic_req_ready;
    in_fire  = in_valid && e_rdy && !flush;
    if (ic_resp_valid) begin
      if (stale > 0) begin
        stale--;
      end else if (outq.size() > 0) begin
        id = outq.pop_front();
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].id == id) begin
            t      = mq[i];
            t.inst = ic_resp_data;
            t.done = 1'b1;
            mq[i]  = t;
          end
        end
      end
    end
    if (flush) begin
      stale += outq.size();
      mq.delete();
      outq.delete();
    end else begin
      if (req_fire || skip) begin
        t        = mq[cand];
        t.passed = 1'b1;
        mq[cand] = t;
        if (req_fire) outq.push_back(t.id);
      end
      if (e_out && out_ready) void'(mq.pop_front());
      if (in_fire) begin
        t.pc     = in_vaddr;
        t.paddr  = in_paddr;
        t.unc    = in_uncached;
        t.excp   = in_excp;
        t.num    = in_excp_num;
        t.inst   = '0;
        t.done   = in_excp;
        t.passed = 1'b0;
        t.id     = next_id++;
        mq.push_back(t);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h1C000000, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b1, 32'h00000000, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 32'h02800000,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[4]  = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b1, 32'h1C000000, 32'h02800000, 1'b0, 4'h0};
    tbl[5]  = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[6]  = '{1'b1, 32'h1C000040, 32'h40, 1'b1, 4'b0010, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b1, 32'h1C000040, 32'h0, 1'b1, 4'b0010};
    tbl[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[9]  = '{1'b1, 32'h1C000100, 32'h100, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[10] = '{1'b1, 32'h1C000104, 32'h104, 1'b1, 4'b0001, 1'b0, 32'h0,
                1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[11] = '{1'b1, 32'h1C000108, 32'h108, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[12] = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b1, 32'h108, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[13] = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 32'h11111111,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};
    tbl[14] = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 32'h33333333,
                1'b1, 1'b0, 32'h0, 1'b1, 32'h1C000100, 32'h11111111, 1'b0, 4'h0};
    tbl[15] = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b1, 32'h1C000104, 32'h0, 1'b1, 4'b0001};
    tbl[16] = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b1, 32'h1C000108, 32'h33333333, 1'b0, 4'h0};
    tbl[17] = '{1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0};

    // Reset state
    reset        = 1'b0;
    ic_req_ready = 1'b1;
    out_ready    = 1'b1;
    idle();
    #3;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset ic_req_valid", ic_req_valid, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick();

    // Vector table: single fetch, exception bypass, mixed ordering
    for (int i = 0; i < 18; i++) begin
      fetch(tbl[i].va, tbl[i].pa, tbl[i].ex, tbl[i].num);
      in_valid = tbl[i].iv;
      resp(tbl[i].rv, tbl[i].rd);
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d ic_req_valid", i), ic_req_valid, tbl[i].e_req);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_out);
      if (tbl[i].e_req) chk($sformatf("vec%0d ic_req_addr", i), ic_req_addr, tbl[i].e_addr);
      if (tbl[i].e_out) begin
        chk($sformatf("vec%0d out_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d out_inst", i), out_inst, tbl[i].e_inst);
        chk($sformatf("vec%0d out_excp", i), out_excp, tbl[i].e_ex);
        chk($sformatf("vec%0d out_excp_num", i), out_excp_num, tbl[i].e_num);
      end
      tick();
    end
    idle();

    // Full queue with decode backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fetch(32'h1C000000 + 32'(4 * k), 32'h400 + 32'(4 * k), 1'b0, 4'h0);
      @(negedge clk);
      chk($sformatf("full alloc%0d in_ready", k), in_ready, 1'b1);
      tick();
    end
    fetch(32'h1C0000F0, 32'h4F0, 1'b0, 4'h0);
    @(negedge clk);
    chk("full in_ready", in_ready, 1'b0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      resp(1'b1, 32'hA0 + 32'(k));
      tick();
    end
    idle();
    @(negedge clk);
    chk("full head out_valid", out_valid, 1'b1);
    chk("full head out_pc", out_pc, 32'h1C000000);
    chk("full head out_inst", out_inst, 32'hA0);
    out_ready = 1'b1;
    fetch(32'h1C000010, 32'h410, 1'b0, 4'h0);
    #1;
    chk("full pop-cycle in_ready", in_ready, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("full after-pop in_ready", in_ready, 1'b1);
    for (int k = 1; k < 4; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("full order%0d out_valid", k), out_valid, 1'b1);
      chk($sformatf("full order%0d out_pc", k), out_pc, 32'h1C000000 + 32'(4 * k));
      chk($sformatf("full order%0d out_inst", k), out_inst, 32'hA0 + 32'(k));
      tick();
    end
    @(negedge clk);
    chk("full drained out_valid", out_valid, 1'b0);
    tick();

    // Flush with two outstanding requests
    fetch(32'h1C000200, 32'h200, 1'b0, 4'h0);
    tick();
    fetch(32'h1C000204, 32'h204, 1'b0, 4'h0);
    tick();
    idle();
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush ic_req_valid", ic_req_valid, 1'b0);
    chk("flush out_valid", out_valid, 1'b0);
    tick();
    flush = 1'b0;
    fetch(32'h1C001000, 32'h1000, 1'b0, 4'h0);
    resp(1'b1, 32'hDEAD0001);
    @(negedge clk);
    chk("flush empty in_ready", in_ready, 1'b1);
    chk("flush empty out_valid", out_valid, 1'b0);
    tick();
    idle();
    resp(1'b1, 32'hDEAD0002);
    @(negedge clk);
    chk("flush reissue ic_req_valid", ic_req_valid, 1'b1);
    chk("flush reissue ic_req_addr", ic_req_addr, 32'h1000);
    tick();
    resp(1'b1, 32'h12345678);
    @(negedge clk);
    chk("flush dropped out_valid", out_valid, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("flush landed out_valid", out_valid, 1'b1);
    chk("flush landed out_pc", out_pc, 32'h1C001000);
    chk("flush landed out_inst", out_inst, 32'h12345678);
    tick();
    @(negedge clk);
    chk("flush drained out_valid", out_valid, 1'b0);
    tick();

    // Reset mid-operation: 3 entries, 2 outstanding
    out_ready = 1'b0;
    fetch(32'h1C000280, 32'h280, 1'b1, 4'b0100);
    tick();
    fetch(32'h1C000284, 32'h284, 1'b0, 4'h0);
    tick();
    fetch(32'h1C000288, 32'h288, 1'b0, 4'h0);
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("prereset out_valid", out_valid, 1'b1);
    chk("prereset out_excp_num", out_excp_num, 4'b0100);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 1'b0);
    chk("midreset ic_req_valid", ic_req_valid, 1'b0);
    chk("midreset in_ready", in_ready, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    tick();
    out_ready = 1'b1;
    fetch(32'h1C000300, 32'h300, 1'b0, 4'h0);
    tick();
    idle();
    @(negedge clk);
    chk("postreset ic_req_valid", ic_req_valid, 1'b1);
    chk("postreset ic_req_addr", ic_req_addr, 32'h300);
    tick();
    resp(1'b1, 32'hCAFE0300);
    @(negedge clk);
    chk("postreset wait out_valid", out_valid, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("postreset out_valid", out_valid, 1'b1);
    chk("postreset out_pc", out_pc, 32'h1C000300);
    chk("postreset out_inst", out_inst, 32'hCAFE0300);
    tick();

    // Random traffic against the reference model
    reset = 1'b0;
    #3 reset = 1'b1;
    tick();
    mq.delete();
    outq.delete();
    stale   = 0;
    next_id = 0;
    for (int c = 0; c < 3000; c++) begin
      flush         = ((stale + outq.size()) <= 8) && ($urandom_range(0, 24) == 0);
      in_valid      = ($urandom_range(0, 2) != 0);
      in_vaddr      = $urandom;
      in_paddr      = $urandom;
      in_uncached   = 1'($urandom_range(0, 1));
      in_excp       = ($urandom_range(0, 5) == 0);
      in_excp_num   = 4'($urandom_range(0, 15));
      ic_req_ready  = ($urandom_range(0, 3) != 0);
      ic_resp_valid = ((stale + outq.size()) > 0) && ($urandom_range(0, 1) == 0);
      ic_resp_data  = $urandom;
      out_ready     = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_cycle(c);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
